// File: rtl/rot_shift_pkg.sv
// Shared types for the serial rotate/shift engine: operation modes and FSM states.
package rot_shift_pkg;

    typedef enum logic [1:0] {
        ROL     = 2'b00,
        ROR     = 2'b01,
        SLL     = 2'b10,
        SRL_SRA = 2'b11
    } rs_mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } rs_state_e;

endpackage

// File: rtl/rot_shift_step.sv
// One-position rotate/shift step (purely combinational).
// Define ROT_SHIFT_ARITH_EN to make mode 11 an arithmetic right shift instead of logical.
module rot_shift_step
    import rot_shift_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] data,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] result
);

    always_comb begin
        result = data;
        unique case (rs_mode_e'(mode))
            ROL:     result = {data[WIDTH-2:0], data[WIDTH-1]};
            ROR:     result = {data[0], data[WIDTH-1:1]};
            SLL:     result = {data[WIDTH-2:0], 1'b0};
`ifdef ROT_SHIFT_ARITH_EN
            SRL_SRA: result = {data[WIDTH-1], data[WIDTH-1:1]};
`else
            SRL_SRA: result = {1'b0, data[WIDTH-1:1]};
`endif
            default: result = data;
        endcase
    end

endmodule

// File: rtl/rot_shift_engine.sv
// Serial rotate/shift engine: one bit position per clock, valid/ready on both sides.
// Mode 11 is SRA when ROT_SHIFT_ARITH_EN is defined, SRL otherwise.
module rot_shift_engine
    import rot_shift_pkg::*;
#(
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amt,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    rs_state_e        state;
    logic [WIDTH-1:0] data_r;
    logic [AMT_W-1:0] cnt;
    rs_mode_e         mode_r;
    logic [WIDTH-1:0] step_data;

    rot_shift_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .data  (data_r),
        .mode  (mode_r),
        .result(step_data)
    );

    // All outputs are registered; out_data is only loaded on entry to DONE so it
    // holds the last result while idle or busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            out_data  <= '0;
            data_r    <= '0;
            cnt       <= '0;
            mode_r    <= ROL;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        data_r   <= in_data;
                        cnt      <= in_amt;
                        mode_r   <= rs_mode_e'(in_mode);
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        if (in_amt == '0) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            out_data  <= in_data;
                        end else begin
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    data_r <= step_data;
                    cnt    <= cnt - AMT_W'(1);
                    if (cnt == AMT_W'(1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        out_data  <= step_data;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
